// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : Bundle of the fetch-stage control, ROM and IF/ID signals.
// Revision : 1.0 - initial release
// ============================================================================

interface inst_fetch_unit_if;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fault;

    // The fetch unit is the master: it drives the ROM address and the IF/ID stage.
    modport master (
        input  stall,
        input  flush,
        input  br_taken,
        input  br_target,
        input  imem_instr,
        output imem_addr,
        output ifid_pc,
        output ifid_instr,
        output ifid_valid,
        output fault
    );

    modport slave (
        output stall,
        output flush,
        output br_taken,
        output br_target,
        output imem_instr,
        input  imem_addr,
        input  ifid_pc,
        input  ifid_instr,
        input  ifid_valid,
        input  fault
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : PC owner and IF/ID register; halts fetch on bad addresses.
// Revision : 1.0 - initial release
// ============================================================================

module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [31:0] NOP_WORD  = 32'hD503201F
) (
    input  wire logic          clk,
    input  wire logic          reset,
    inst_fetch_unit_if.master  bus
);

    localparam logic [63:0] c_MEM_LIMIT = 64'(MEM_BYTES);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [63:0] r_pc;
    logic [63:0] w_nxt_pc;
    logic [63:0] r_ifid_pc;
    logic [63:0] w_nxt_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] w_nxt_ifid_instr;
    logic        r_ifid_valid;
    logic        w_nxt_ifid_valid;
    logic        r_fault;
    logic        w_nxt_fault;

    logic [63:0] w_pc_plus3;
    logic [63:0] w_pc_plus4;
    logic        w_addr_bad;

    // An aligned PC cannot wrap on +3, so the range check also catches PC+4 wraps.
    assign w_pc_plus3 = r_pc + 64'd3;
    assign w_pc_plus4 = r_pc + 64'd4;
    assign w_addr_bad = (r_pc[1:0] != 2'b00) || (w_pc_plus3 >= c_MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= 64'd0;
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pc         <= w_nxt_pc;
            r_ifid_pc    <= w_nxt_ifid_pc;
            r_ifid_instr <= w_nxt_ifid_instr;
            r_ifid_valid <= w_nxt_ifid_valid;
            r_fault      <= w_nxt_fault;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_pc         = r_pc;
        w_nxt_ifid_pc    = r_ifid_pc;
        w_nxt_ifid_instr = r_ifid_instr;
        w_nxt_ifid_valid = r_ifid_valid;
        w_nxt_fault      = r_fault;

        case (r_state)
            ST_RUN: begin
                if (w_addr_bad) begin
                    w_nxt_state      = ST_HALT;
                    w_nxt_fault      = 1'b1;
                    w_nxt_ifid_valid = 1'b0;
                    w_nxt_ifid_instr = NOP_WORD;
                end else if (bus.br_taken) begin
                    // Wrong-path fetch is squashed even under stall or flush.
                    w_nxt_pc         = bus.br_target;
                    w_nxt_ifid_valid = 1'b0;
                    w_nxt_ifid_instr = NOP_WORD;
                end else if (bus.stall) begin
                    w_nxt_pc         = r_pc;
                end else if (bus.flush) begin
                    w_nxt_pc         = w_pc_plus4;
                    w_nxt_ifid_valid = 1'b0;
                    w_nxt_ifid_instr = NOP_WORD;
                end else begin
                    w_nxt_pc         = w_pc_plus4;
                    w_nxt_ifid_pc    = r_pc;
                    w_nxt_ifid_instr = bus.imem_instr;
                    w_nxt_ifid_valid = 1'b1;
                end
            end
            ST_HALT: begin
                w_nxt_ifid_valid = 1'b0;
                w_nxt_ifid_instr = NOP_WORD;
                w_nxt_fault      = 1'b1;
            end
        endcase
    end

    assign bus.imem_addr  = r_pc;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_valid = r_ifid_valid;
    assign bus.fault      = r_fault;

endmodule

`default_nettype wire
